// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: states, opcodes,
// function codes, mux-select encodings and ALU operation codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_WB_R    = 4'd3,
    S_EXEC_I  = 4'd4,
    S_WB_I    = 4'd5,
    S_ADDR    = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_WB_MEM  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12
  } ctrl_state_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_RALU    = 4'd1,
    CLS_JR      = 4'd2,
    CLS_ORI     = 4'd3,
    CLS_LUI     = 4'd4,
    CLS_LW      = 4'd5,
    CLS_SW      = 4'd6,
    CLS_BEQ     = 4'd7,
    CLS_J       = 4'd8
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  localparam logic [1:0] SRCA_PC      = 2'd0;
  localparam logic [1:0] SRCA_REGA    = 2'd1;
  localparam logic [1:0] SRCA_C16     = 2'd2;

  localparam logic [2:0] SRCB_REGB    = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_SEXT    = 3'd2;
  localparam logic [2:0] SRCB_SEXT_SH = 3'd3;
  localparam logic [2:0] SRCB_ZEXT    = 3'd4;

  localparam logic [5:0] ALU_LSHIFT = 6'h04;
  localparam logic [5:0] ALU_ADD    = 6'h20;
  localparam logic [5:0] ALU_ADDU   = 6'h21;
  localparam logic [5:0] ALU_SUB    = 6'h22;
  localparam logic [5:0] ALU_SUBU   = 6'h23;
  localparam logic [5:0] ALU_OR     = 6'h25;
  localparam logic [5:0] ALU_SLT    = 6'h2A;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multi-cycle controller and the datapath.
interface multicycle_controller_if;
  logic [31:0] instr;
  logic        regsEqual;
  logic        memReady;
  logic        memRead;
  logic        memWrite;
  logic        irWrite;
  logic        pcWrite;
  logic [1:0]  pcSrc;
  logic [1:0]  aluSrcA;
  logic [2:0]  aluSrcB;
  logic [5:0]  aluOp;
  logic        regWrite;
  logic        regDst;
  logic        memToReg;
  logic        illegalInst;
  logic [3:0]  state;

  modport master (
    input  instr, regsEqual, memReady,
    output memRead, memWrite, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
           aluOp, regWrite, regDst, memToReg, illegalInst, state
  );

  modport slave (
    output instr, regsEqual, memReady,
    input  memRead, memWrite, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
           aluOp, regWrite, regDst, memToReg, illegalInst, state
  );
endinterface

// File: rtl/multicycle_controller_instr_field_decoder.sv
// Classifies an instruction by opcode/funct and picks the R-type ALU operation.
module instr_field_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t instrClass,
  output logic [5:0]   rAluOp
);

  always_comb begin
    instrClass = CLS_ILLEGAL;
    rAluOp     = ALU_ADDU;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin instrClass = CLS_RALU; rAluOp = ALU_ADDU; end
          FN_SUBU: begin instrClass = CLS_RALU; rAluOp = ALU_SUBU; end
          FN_SLT:  begin instrClass = CLS_RALU; rAluOp = ALU_SLT;  end
          FN_JR:   instrClass = CLS_JR;
          default: instrClass = CLS_ILLEGAL;
        endcase
      end
      OP_ORI:  instrClass = CLS_ORI;
      OP_LUI:  instrClass = CLS_LUI;
      OP_LW:   instrClass = CLS_LW;
      OP_SW:   instrClass = CLS_SW;
      OP_BEQ:  instrClass = CLS_BEQ;
      OP_J:    instrClass = CLS_J;
      default: instrClass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and
// decodes all datapath selects and write enables from state, instr and memReady.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter ctrl_state_t RESET_STATE         = S_FETCH,
  parameter bit          ENABLE_ILLEGAL_TRAP = 1'b1
)
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  ctrl_state_t  curState, nextState;
  instr_class_t instrClass;
  logic [5:0]   rAluOp;

  logic       memReadC, memWriteC, irWriteC, pcWriteC;
  logic [1:0] pcSrcC, aluSrcAC;
  logic [2:0] aluSrcBC;
  logic [5:0] aluOpC;
  logic       regWriteC, regDstC, memToRegC, illegalC;

  instr_field_decoder uDecoder (
    .opcode     (bus.instr[31:26]),
    .funct      (bus.instr[5:0]),
    .instrClass (instrClass),
    .rAluOp     (rAluOp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) curState <= RESET_STATE;
    else       curState <= nextState;
  end

  always_comb begin
    nextState = S_FETCH;
    memReadC  = 1'b0;
    memWriteC = 1'b0;
    irWriteC  = 1'b0;
    pcWriteC  = 1'b0;
    pcSrcC    = PCSRC_ALU;
    aluSrcAC  = SRCA_PC;
    aluSrcBC  = SRCB_REGB;
    aluOpC    = '0;
    regWriteC = 1'b0;
    regDstC   = 1'b0;
    memToRegC = 1'b0;
    illegalC  = 1'b0;
    case (curState)
      S_FETCH: begin
        memReadC = 1'b1;
        aluSrcBC = SRCB_FOUR;
        aluOpC   = ALU_ADD;
        if (bus.memReady) begin
          irWriteC  = 1'b1;
          pcWriteC  = 1'b1;
          nextState = S_DECODE;
        end else begin
          nextState = S_FETCH;
        end
      end
      S_DECODE: begin
        aluSrcBC = SRCB_SEXT_SH;
        aluOpC   = ALU_ADD;
        case (instrClass)
          CLS_RALU:        nextState = S_EXEC_R;
          CLS_JR:          nextState = S_JR;
          CLS_ORI, CLS_LUI: nextState = S_EXEC_I;
          CLS_LW, CLS_SW:  nextState = S_ADDR;
          CLS_BEQ:         nextState = S_BRANCH;
          CLS_J:           nextState = S_JUMP;
          default: begin
            illegalC  = ENABLE_ILLEGAL_TRAP;
            nextState = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        aluSrcAC  = SRCA_REGA;
        aluOpC    = rAluOp;
        nextState = S_WB_R;
      end
      S_WB_R: begin
        regWriteC = 1'b1;
        regDstC   = 1'b1;
        aluOpC    = rAluOp;
      end
      S_EXEC_I: begin
        aluSrcBC  = SRCB_ZEXT;
        if (instrClass == CLS_LUI) begin
          aluSrcAC = SRCA_C16;
          aluOpC   = ALU_LSHIFT;
        end else begin
          aluSrcAC = SRCA_REGA;
          aluOpC   = ALU_OR;
        end
        nextState = S_WB_I;
      end
      S_WB_I: regWriteC = 1'b1;
      S_ADDR: begin
        aluSrcAC  = SRCA_REGA;
        aluSrcBC  = SRCB_SEXT;
        aluOpC    = ALU_ADD;
        nextState = (instrClass == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        memReadC  = 1'b1;
        nextState = bus.memReady ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        memWriteC = 1'b1;
        nextState = bus.memReady ? S_FETCH : S_MEM_WR;
      end
      S_WB_MEM: begin
        regWriteC = 1'b1;
        memToRegC = 1'b1;
      end
      S_BRANCH: begin
        aluSrcAC = SRCA_REGA;
        aluOpC   = ALU_SUB;
        pcSrcC   = PCSRC_ALUOUT;
        pcWriteC = bus.regsEqual;
      end
      S_JUMP: begin
        pcSrcC   = PCSRC_JUMP;
        pcWriteC = 1'b1;
      end
      S_JR: begin
        pcSrcC   = PCSRC_REGA;
        pcWriteC = 1'b1;
      end
      default: nextState = S_FETCH;
    endcase
    // Reset is asynchronous, so the outputs must fall back immediately rather
    // than waiting for the state register to settle on an edge.
    if (reset) begin
      memReadC  = 1'b0;
      memWriteC = 1'b0;
      irWriteC  = 1'b0;
      pcWriteC  = 1'b0;
      pcSrcC    = PCSRC_ALU;
      aluSrcAC  = SRCA_PC;
      aluSrcBC  = SRCB_REGB;
      aluOpC    = ALU_ADD;
      regWriteC = 1'b0;
      regDstC   = 1'b0;
      memToRegC = 1'b0;
      illegalC  = 1'b0;
    end
  end

  assign bus.memRead     = memReadC;
  assign bus.memWrite    = memWriteC;
  assign bus.irWrite     = irWriteC;
  assign bus.pcWrite     = pcWriteC;
  assign bus.pcSrc       = pcSrcC;
  assign bus.aluSrcA     = aluSrcAC;
  assign bus.aluSrcB     = aluSrcBC;
  assign bus.aluOp       = aluOpC;
  assign bus.regWrite    = regWriteC;
  assign bus.regDst      = regDstC;
  assign bus.memToReg    = memToRegC;
  assign bus.illegalInst = illegalC;
  assign bus.state       = curState;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, corner
// sequences (memory stalls, async reset) and random instruction streams.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw, ir, pw;
    logic [1:0] ps, sa;
    logic [2:0] sb;
    logic [5:0] op;
    logic       rw, rd, m2r, ill;
  } outv_t;

  typedef struct {
    logic [31:0] instr;
    logic        regsEq;
    logic        memRdy;
    outv_t       exp;
  } vec_t;

  localparam int K_R = 0, K_JR = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_ILL = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.RESET_STATE(S_FETCH), .ENABLE_ILLEGAL_TRAP(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;
  vec_t tbl[$];
  vec_t tl[$];

  function automatic outv_t actual();
    outv_t a;
    a.st = bus.state;   a.mr = bus.memRead;  a.mw = bus.memWrite;
    a.ir = bus.irWrite; a.pw = bus.pcWrite;  a.ps = bus.pcSrc;
    a.sa = bus.aluSrcA; a.sb = bus.aluSrcB;  a.op = bus.aluOp;
    a.rw = bus.regWrite; a.rd = bus.regDst;  a.m2r = bus.memToReg;
    a.ill = bus.illegalInst;
    return a;
  endfunction

  function automatic outv_t blank(ctrl_state_t s);
    outv_t o = '0;
    o.st = s;
    return o;
  endfunction

  // Per-phase expectations, written straight from the phase descriptions.
  function automatic outv_t fetchO(logic rdy);
    outv_t o = blank(S_FETCH);
    o.mr = 1; o.sb = 3'd1; o.op = ALU_ADD; o.ir = rdy; o.pw = rdy;
    return o;
  endfunction
  function automatic outv_t decodeO(logic ill);
    outv_t o = blank(S_DECODE);
    o.sb = 3'd3; o.op = ALU_ADD; o.ill = ill;
    return o;
  endfunction
  function automatic outv_t execRO(logic [5:0] op);
    outv_t o = blank(S_EXEC_R);
    o.sa = 2'd1; o.op = op;
    return o;
  endfunction
  function automatic outv_t wbRO(logic [5:0] op);
    outv_t o = blank(S_WB_R);
    o.rw = 1; o.rd = 1; o.op = op;
    return o;
  endfunction
  function automatic outv_t execIO(logic isLui);
    outv_t o = blank(S_EXEC_I);
    o.sb = 3'd4;
    o.sa = isLui ? 2'd2 : 2'd1;
    o.op = isLui ? ALU_LSHIFT : ALU_OR;
    return o;
  endfunction
  function automatic outv_t wbIO();
    outv_t o = blank(S_WB_I);
    o.rw = 1;
    return o;
  endfunction
  function automatic outv_t addrO();
    outv_t o = blank(S_ADDR);
    o.sa = 2'd1; o.sb = 3'd2; o.op = ALU_ADD;
    return o;
  endfunction
  function automatic outv_t memRdO();
    outv_t o = blank(S_MEM_RD);
    o.mr = 1;
    return o;
  endfunction
  function automatic outv_t memWrO();
    outv_t o = blank(S_MEM_WR);
    o.mw = 1;
    return o;
  endfunction
  function automatic outv_t wbMemO();
    outv_t o = blank(S_WB_MEM);
    o.rw = 1; o.m2r = 1;
    return o;
  endfunction
  function automatic outv_t branchO(logic eq);
    outv_t o = blank(S_BRANCH);
    o.sa = 2'd1; o.op = ALU_SUB; o.ps = 2'd1; o.pw = eq;
    return o;
  endfunction
  function automatic outv_t jumpO();
    outv_t o = blank(S_JUMP);
    o.ps = 2'd2; o.pw = 1;
    return o;
  endfunction
  function automatic outv_t jrO();
    outv_t o = blank(S_JR);
    o.ps = 2'd3; o.pw = 1;
    return o;
  endfunction
  function automatic outv_t resetO();
    outv_t o = blank(S_FETCH);
    o.op = ALU_ADD;
    return o;
  endfunction

  function automatic int kindOf(logic [31:0] i);
    case (i[31:26])
      6'h00: case (i[5:0])
               6'h21, 6'h23, 6'h2A: return K_R;
               6'h08:               return K_JR;
               default:             return K_ILL;
             endcase
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [5:0] rOp(logic [5:0] fn);
    case (fn)
      6'h23:   return ALU_SUBU;
      6'h2A:   return ALU_SLT;
      default: return ALU_ADDU;
    endcase
  endfunction

  function automatic vec_t mkv(logic [31:0] i, logic eq, logic rdy, outv_t e);
    vec_t v;
    v.instr = i; v.regsEq = eq; v.memRdy = rdy; v.exp = e;
    return v;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference timeline for one instruction: cycle-by-cycle expectations.
  task automatic buildTimeline(input logic [31:0] i, input logic eq,
                               input int stallF, input int stallM);
    int k = kindOf(i);
    for (int n = 0; n < stallF; n++) tl.push_back(mkv(i, eq, 1'b0, fetchO(1'b0)));
    tl.push_back(mkv(i, eq, 1'b1, fetchO(1'b1)));
    tl.push_back(mkv(i, eq, rbit(), decodeO(k == K_ILL)));
    case (k)
      K_R: begin
        tl.push_back(mkv(i, eq, rbit(), execRO(rOp(i[5:0]))));
        tl.push_back(mkv(i, eq, rbit(), wbRO(rOp(i[5:0]))));
      end
      K_ORI, K_LUI: begin
        tl.push_back(mkv(i, eq, rbit(), execIO(k == K_LUI)));
        tl.push_back(mkv(i, eq, rbit(), wbIO()));
      end
      K_LW: begin
        tl.push_back(mkv(i, eq, rbit(), addrO()));
        for (int n = 0; n < stallM; n++) tl.push_back(mkv(i, eq, 1'b0, memRdO()));
        tl.push_back(mkv(i, eq, 1'b1, memRdO()));
        tl.push_back(mkv(i, eq, rbit(), wbMemO()));
      end
      K_SW: begin
        tl.push_back(mkv(i, eq, rbit(), addrO()));
        for (int n = 0; n < stallM; n++) tl.push_back(mkv(i, eq, 1'b0, memWrO()));
        tl.push_back(mkv(i, eq, 1'b1, memWrO()));
      end
      K_BEQ: tl.push_back(mkv(i, eq, rbit(), branchO(eq)));
      K_J:   tl.push_back(mkv(i, eq, rbit(), jumpO()));
      K_JR:  tl.push_back(mkv(i, eq, rbit(), jrO()));
      default: ;
    endcase
  endtask

  task automatic compare(input string name, input outv_t exp);
    outv_t a = actual();
    checks++;
    if (a === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, a, exp, $time);
  endtask

  task automatic applyCycle(input string name, input vec_t v);
    bus.instr     = v.instr;
    bus.regsEqual = v.regsEq;
    bus.memReady  = v.memRdy;
    #2;
    compare(name, v.exp);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (bus.memRead && bus.memWrite)
        $display("FAIL memExclusive: memRead=%b memWrite=%b required not both 1", bus.memRead, bus.memWrite);
      else passes++;
    end
  end

  initial begin
    logic [31:0] ri;
    int sel;
    reset = 1'b1;
    bus.instr = '0; bus.regsEqual = 1'b0; bus.memReady = 1'b0;
    #2;
    compare("resetState", resetO());
    #10;
    reset = 1'b0;

    // Directed vector table; each row is one clock cycle of a continuous stream.
    tbl.push_back(mkv(32'h00221821, 0, 1, fetchO(1)));
    tbl.push_back(mkv(32'h00221821, 0, 0, decodeO(0)));
    tbl.push_back(mkv(32'h00221821, 0, 1, execRO(ALU_ADDU)));
    tbl.push_back(mkv(32'h00221821, 0, 0, wbRO(ALU_ADDU)));
    tbl.push_back(mkv(32'h3C011234, 0, 0, fetchO(0)));
    tbl.push_back(mkv(32'h3C011234, 0, 1, fetchO(1)));
    tbl.push_back(mkv(32'h3C011234, 0, 1, decodeO(0)));
    tbl.push_back(mkv(32'h3C011234, 0, 0, execIO(1)));
    tbl.push_back(mkv(32'h3C011234, 0, 1, wbIO()));
    tbl.push_back(mkv(32'h10220001, 1, 1, fetchO(1)));
    tbl.push_back(mkv(32'h10220001, 1, 0, decodeO(0)));
    tbl.push_back(mkv(32'h10220001, 1, 0, branchO(1)));
    tbl.push_back(mkv(32'h10220001, 0, 1, fetchO(1)));
    tbl.push_back(mkv(32'h10220001, 0, 1, decodeO(0)));
    tbl.push_back(mkv(32'h10220001, 0, 1, branchO(0)));
    tbl.push_back(mkv(32'hFC000000, 0, 1, fetchO(1)));
    tbl.push_back(mkv(32'hFC000000, 0, 1, decodeO(1)));
    tbl.push_back(mkv(32'hAC220008, 0, 1, fetchO(1)));
    tbl.push_back(mkv(32'hAC220008, 0, 0, decodeO(0)));
    tbl.push_back(mkv(32'hAC220008, 0, 1, addrO()));
    tbl.push_back(mkv(32'hAC220008, 0, 0, memWrO()));
    tbl.push_back(mkv(32'hAC220008, 0, 1, memWrO()));
    tbl.push_back(mkv(32'h08000010, 0, 1, fetchO(1)));
    tbl.push_back(mkv(32'h08000010, 0, 0, decodeO(0)));
    tbl.push_back(mkv(32'h08000010, 0, 1, jumpO()));
    tbl.push_back(mkv(32'h03E00008, 0, 1, fetchO(1)));
    tbl.push_back(mkv(32'h03E00008, 0, 1, decodeO(0)));
    tbl.push_back(mkv(32'h03E00008, 0, 0, jrO()));
    tbl.push_back(mkv(32'h34220055, 0, 1, fetchO(1)));
    tbl.push_back(mkv(32'h34220055, 0, 1, decodeO(0)));
    tbl.push_back(mkv(32'h34220055, 0, 1, execIO(0)));
    tbl.push_back(mkv(32'h34220055, 0, 0, wbIO()));
    tbl.push_back(mkv(32'h0022182A, 0, 0, fetchO(0)));
    foreach (tbl[n]) applyCycle($sformatf("table[%0d]", n), tbl[n]);

    // lw with two stall cycles in MEM_RD: seven cycles, memRead held three.
    tl.delete();
    tl.push_back(mkv(32'h8C220004, 0, 1, fetchO(1)));
    tl.push_back(mkv(32'h8C220004, 0, 0, decodeO(0)));
    tl.push_back(mkv(32'h8C220004, 0, 0, addrO()));
    tl.push_back(mkv(32'h8C220004, 0, 0, memRdO()));
    tl.push_back(mkv(32'h8C220004, 0, 0, memRdO()));
    tl.push_back(mkv(32'h8C220004, 0, 1, memRdO()));
    tl.push_back(mkv(32'h8C220004, 0, 0, wbMemO()));
    tl.push_back(mkv(32'h8C220004, 0, 0, fetchO(0)));
    foreach (tl[n]) applyCycle($sformatf("lwStall[%0d]", n), tl[n]);

    // Async reset in the middle of a stalled store.
    tl.delete();
    tl.push_back(mkv(32'hAC220008, 0, 1, fetchO(1)));
    tl.push_back(mkv(32'hAC220008, 0, 0, decodeO(0)));
    tl.push_back(mkv(32'hAC220008, 0, 0, addrO()));
    foreach (tl[n]) applyCycle($sformatf("swPre[%0d]", n), tl[n]);
    bus.memReady = 1'b0;
    #2;
    compare("midMemWr", memWrO());
    #1;
    reset = 1'b1;
    #1;
    compare("asyncResetDrop", resetO());
    @(posedge clk);
    #2;
    compare("resetHeld", resetO());
    reset = 1'b0;
    #1;
    applyCycle("postResetFetch", mkv(32'h00000000, 0, 0, fetchO(0)));

    // Random instruction stream against the timeline model.
    for (int t = 0; t < 150; t++) begin
      ri = $urandom;
      sel = $urandom_range(0, 10);
      case (sel)
        0: begin ri[31:26] = 6'h00; ri[10:0] = 11'h021; end
        1: begin ri[31:26] = 6'h00; ri[10:0] = 11'h023; end
        2: begin ri[31:26] = 6'h00; ri[10:0] = 11'h02A; end
        3: begin ri[31:26] = 6'h00; ri[20:0] = 21'h000008; end
        4: ri[31:26] = 6'h0D;
        5: begin ri[31:26] = 6'h0F; ri[25:21] = 5'd0; end
        6: ri[31:26] = 6'h23;
        7: ri[31:26] = 6'h2B;
        8: ri[31:26] = 6'h04;
        9: ri[31:26] = 6'h02;
        default: while (kindOf(ri) != K_ILL) ri = $urandom;
      endcase
      tl.delete();
      buildTimeline(ri, rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
      foreach (tl[n]) applyCycle($sformatf("rand%0d[%0d] instr=%h", t, n, ri), tl[n]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, checks=%0d passes=%0d", checks, passes);
    $fatal(1, "timeout");
  end

endmodule
